// File: rtl/leaf_net_iface.sv
// leaf_net_iface: leaf core <-> 11-bit CSP router port using four-phase bundled-data handshakes.
// Optional receive address filter with misroute counter: define NI_ADDR_CHECK_EN.
module leaf_net_iface #(
   parameter int WIDTH       = 11,
   parameter int ADDR_W      = 3,
   parameter int TX_DEPTH    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int MY_ADDR     = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   input  logic [ADDR_W-1:0]       tx_dest,
   input  logic [WIDTH-ADDR_W-1:0] tx_payload,
   output logic                    rx_valid,
   input  logic                    rx_ready,
   output logic [WIDTH-1:0]        rx_flit,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_req,
   input  logic                    out_ack,
   input  logic [WIDTH-1:0]        in_data,
   input  logic                    in_req,
   output logic                    in_ack,
   output logic [7:0]              misroute_cnt
);
   localparam int PW = $clog2(TX_DEPTH);

   typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_REL} tx_st_t;
   typedef enum logic {RX_WAIT, RX_ACK} rx_st_t;

   tx_st_t                 r_tx_st;
   rx_st_t                 r_rx_st;
   logic [WIDTH-1:0]       r_tx_mem [TX_DEPTH];
   logic [PW:0]            r_tx_wp, r_tx_rp;
   logic                   r_init, r_out_req, r_in_ack;
   logic [WIDTH-1:0]       r_out_data;
   logic [SYNC_STAGES-1:0] r_ack_sync, r_req_sync;
   logic [WIDTH-1:0]       r_rx_mem [2];
   logic                   r_rx_wp, r_rx_rp;
   logic [1:0]             r_rx_cnt;
   logic                   w_ack_s, w_req_s, w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
   logic                   w_rx_full, w_rx_take, w_rx_push, w_rx_pop, w_addr_hit, w_keep;

`ifdef NI_ADDR_CHECK_EN
   localparam bit LP_ADDR_CHK = 1'b1;
   logic [7:0] r_miss;

   // Misrouted flits are acked but dropped; count saturates rather than wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_miss <= 8'd0;
      else if (w_rx_take && !w_addr_hit && r_miss != 8'hFF)
         r_miss <= r_miss + 8'd1;
   end
   assign misroute_cnt = r_miss;
`else
   localparam bit LP_ADDR_CHK = 1'b0;
   assign misroute_cnt = 8'd0;
`endif

   assign w_ack_s    = r_ack_sync[SYNC_STAGES-1];
   assign w_req_s    = r_req_sync[SYNC_STAGES-1];
   assign w_tx_full  = (r_tx_wp[PW] != r_tx_rp[PW]) && (r_tx_wp[PW-1:0] == r_tx_rp[PW-1:0]);
   assign w_tx_empty = (r_tx_wp == r_tx_rp);
   assign tx_ready   = r_init && !w_tx_full;
   assign w_tx_push  = tx_valid && tx_ready;
   assign w_tx_pop   = (r_tx_st == TX_REQ) && w_ack_s;
   assign out_req    = r_out_req;
   assign out_data   = r_out_data;

   assign w_rx_full  = (r_rx_cnt == 2'd2);
   assign rx_valid   = (r_rx_cnt != 2'd0);
   assign rx_flit    = r_rx_mem[r_rx_rp];
   assign w_rx_pop   = rx_valid && rx_ready;
   assign w_rx_take  = (r_rx_st == RX_WAIT) && w_req_s && !w_rx_full;
   assign w_addr_hit = (in_data[WIDTH-1 -: ADDR_W] == ADDR_W'(MY_ADDR));
   assign w_keep     = w_addr_hit || !LP_ADDR_CHK;
   assign w_rx_push  = w_rx_take && w_keep;
   assign in_ack     = r_in_ack;

   always_ff @(posedge clk) begin
      if (w_tx_push)
         r_tx_mem[r_tx_wp[PW-1:0]] <= {tx_dest, tx_payload};
   end

   // TX side: r_init keeps tx_ready low until the first edge after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_st    <= TX_IDLE;
         r_out_req  <= 1'b0;
         r_out_data <= '0;
         r_tx_wp    <= '0;
         r_tx_rp    <= '0;
         r_init     <= 1'b0;
         r_ack_sync <= '0;
      end else begin
         r_init     <= 1'b1;
         r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], out_ack};
         if (w_tx_push)
            r_tx_wp <= r_tx_wp + (PW+1)'(1);
         if (w_tx_pop)
            r_tx_rp <= r_tx_rp + (PW+1)'(1);
         case (r_tx_st)
            TX_IDLE: if (!w_tx_empty) begin
               r_out_data <= r_tx_mem[r_tx_rp[PW-1:0]];
               r_out_req  <= 1'b1;
               r_tx_st    <= TX_REQ;
            end
            TX_REQ: if (w_ack_s) begin
               r_out_req <= 1'b0;
               r_tx_st   <= TX_REL;
            end
            TX_REL: if (!w_ack_s) r_tx_st <= TX_IDLE;
            default: r_tx_st <= TX_IDLE;
         endcase
      end
   end

   // RX side: a full buffer holds off the ack, which back-pressures the router.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_st    <= RX_WAIT;
         r_in_ack   <= 1'b0;
         r_req_sync <= '0;
         r_rx_wp    <= 1'b0;
         r_rx_rp    <= 1'b0;
         r_rx_cnt   <= 2'd0;
         r_rx_mem[0] <= '0;
         r_rx_mem[1] <= '0;
      end else begin
         r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], in_req};
         if (w_rx_push) begin
            r_rx_mem[r_rx_wp] <= in_data;
            r_rx_wp           <= ~r_rx_wp;
         end
         if (w_rx_pop)
            r_rx_rp <= ~r_rx_rp;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + 2'd1;
            2'b01:   r_rx_cnt <= r_rx_cnt - 2'd1;
            default: r_rx_cnt <= r_rx_cnt;
         endcase
         case (r_rx_st)
            RX_WAIT: if (w_rx_take) begin
               r_in_ack <= 1'b1;
               r_rx_st  <= RX_ACK;
            end
            RX_ACK: if (!w_req_s) begin
               r_in_ack <= 1'b0;
               r_rx_st  <= RX_WAIT;
            end
            default: r_rx_st <= RX_WAIT;
         endcase
      end
   end
endmodule

// File: doc/leaf_net_iface.md
# leaf_net_iface

Clocked network interface between a leaf core and one 11-bit CSP router port. Packs core send requests into flits, drives them onto the router's input channel with a four-phase bundled-data req/ack handshake, and unpacks flits from the router's output channel into a core-side receive buffer. Router handshake inputs are asynchronous to `clk` and are synchronized internally.

## Interface
- `WIDTH`, 11, flit width; fixed at 11 to match the router channels.
- `ADDR_W`, 3, destination field width; flit[10:8].
- `TX_DEPTH`, 4, transmit FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2, flops in each req/ack synchronizer; ≥2.
- `MY_ADDR`, 0, this leaf's address.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `tx_valid` in 1: core offers a flit.
- `tx_ready` out 1: TX FIFO not full.
- `tx_dest` in 3: destination leaf.
- `tx_payload` in 8: payload.
- `rx_valid` out 1: RX buffer non-empty.
- `rx_ready` in 1: core consumes head.
- `rx_flit` out 11: head of RX buffer.
- `out_data` out 11: flit to router input port.
- `out_req` out 1: four-phase request to router.
- `out_ack` in 1: router acknowledge (async).
- `in_data` in 11: flit from router output port.
- `in_req` in 1: router request (async).
- `in_ack` out 1: acknowledge to router.
- `misroute_cnt` out 8: dropped-flit count (see Configuration).

## Operation
- Flit format: [10:8] = dest, [7:0] = payload.
- TX push: `tx_valid && tx_ready` at a rising edge writes {tx_dest, tx_payload}. `tx_ready` = !full and does not account for a same-cycle pop.
- TX FSM, ack sampled as `ack_s` (after SYNC_STAGES flops):
  - IDLE: FIFO non-empty → REQ. `out_data` loads the head; `out_req` = 1.
  - REQ: `ack_s` = 1 → RELEASE. `out_req` = 0; FIFO pops.
  - RELEASE: `ack_s` = 0 → IDLE.
- `out_data` is registered. It is stable from `out_req` rise until the RELEASE→IDLE edge.
- RX FSM, req sampled as `req_s`:
  - WAIT: `req_s` = 1 and RX buffer not full → ACK. `in_data` is captured into the buffer; `in_ack` = 1.
  - ACK: `req_s` = 0 → WAIT. `in_ack` = 0.
  - When `req_s` = 1 and the buffer is full, the FSM stays in WAIT and `in_ack` stays 0. This backpressure to the router is required.
- RX buffer: 2-entry FIFO. Pop on `rx_valid && rx_ready`. Simultaneous push and pop is legal; occupancy is unchanged.
- The two FSMs are independent; both may advance in the same cycle.

## Timing
- Reset values: `out_req`, `in_ack`, `tx_ready`, `rx_valid` = 0; `out_data`, `rx_flit`, `misroute_cnt` = 0. `tx_ready` rises on the first edge after reset deasserts.
- Reset mid-operation immediately drops `out_req` and `in_ack`, empties both FIFOs, and returns the FSMs to IDLE/WAIT. In-flight flits are lost. The router shares `reset`.
- Push at edge T into an empty FIFO with TX in IDLE: `out_req` = 1 after edge T+1.
- Router ack rising → `out_req` falls after SYNC_STAGES+1 edges.
- Router ack falling → next flit's `out_req` rises after SYNC_STAGES+2 edges.
- `in_req` rising → `in_ack` = 1 and `rx_valid` = 1 after SYNC_STAGES+1 edges.
- Minimum TX cycle per flit with zero-delay router: 2·SYNC_STAGES+3 clocks.

## Configuration
- `NI_ADDR_CHECK_EN` defined: a received flit with [10:8] ≠ MY_ADDR is still acknowledged normally but is not written to the RX buffer. `misroute_cnt` increments, saturating at 255.
- Undefined: every flit is buffered and `misroute_cnt` is tied to 0.

## Test plan
- Reset with ack looped back through a 1-cycle delay; push dest=5, payload=0xA3. Expect `out_data` = 0x5A3, `out_req` high at T+1, one full four-phase handshake, FIFO empty.
- Hold `out_ack` = 0 and push 5 flits. Expect `tx_ready` = 0 after the 4th push, the 5th push is refused, `out_req` holds with the first flit stable.
- Router sends 0x012, then 0x034 with `rx_ready` = 0, then a third flit. Expect 2 buffered, the third `in_req` left un-acked; after one pop it is acked and `rx_flit` order is 0x012, 0x034, 0x0xx.
- Assert `reset` while `out_req` = 1 and `in_ack` = 1. Expect both outputs to go 0 combinationally, both FIFOs empty, `misroute_cnt` = 0.
- With `NI_ADDR_CHECK_EN` and MY_ADDR = 0, receive 0x3FF then 0x055. Expect both acked, only 0x055 buffered, `misroute_cnt` = 1. Without the macro, expect both buffered and the count to stay 0.
- TX and RX handshakes active concurrently with an RX push/pop in the same cycle. Expect no lost or duplicated flits.
